seq_mult_signed: RTL and testbench

Parametrised shift-add sequential multiplier with a single controller and datapath. It supports unsigned and two's-complement signed operands, selected per operation. It uses a Start/Ready/Done handshake and holds the product after completion. It serves as a compact multiply resource for control-path logic where a full array multiplier is too costly.

---
 rtl/seq_mult_signed.sv | 126 ++++++++++++
 tb/tb_seq_mult_signed.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_signed.sv
// seq_mult_signed: shift-add sequential multiplier, unsigned or two's-complement per operation.
// Optional macro SEQ_MULT_SKIP_EN folds zero multiplier bits into a single shift cycle.
module seq_mult_signed #(
    parameter int DP_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_b,
    input  logic                  Start,
    input  logic                  Signed_mode,
    input  logic [DP_WIDTH-1:0]   Multiplicand,
    input  logic [DP_WIDTH-1:0]   Multiplier,
    output logic [2*DP_WIDTH-1:0] Product,
    output logic                  Ready,
    output logic                  Done
);
    localparam int BC_SIZE = $clog2(DP_WIDTH + 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ADD   = 4'b0010,
        S_SHIFT = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    state_t              r_state;
    logic [DP_WIDTH:0]   r_a;
    logic [DP_WIDTH-1:0] r_b;
    logic [DP_WIDTH-1:0] r_q;
    logic [BC_SIZE-1:0]  r_p;
    logic                r_s;

    logic [DP_WIDTH:0]   w_b_ext;
    logic [DP_WIDTH:0]   w_a_sum;
    logic [DP_WIDTH:0]   w_a_diff;
    logic [DP_WIDTH:0]   w_a_upd;
    logic [DP_WIDTH:0]   w_a_sh;
    logic [DP_WIDTH-1:0] w_q_sh;
    logic                w_last;

    always_comb begin
        w_b_ext  = {r_s & r_b[DP_WIDTH-1], r_b};
        w_a_sum  = r_s ? (r_a + w_b_ext)
                       : ({1'b0, r_a[DP_WIDTH-1:0]} + {1'b0, r_b});
        w_a_diff = r_a - w_b_ext;
        w_last   = (r_p == BC_SIZE'(1));
        // Multiplier MSB has negative weight in signed mode, so the last add becomes a subtract.
        w_a_upd  = (r_s && w_last) ? w_a_diff : w_a_sum;
        w_a_sh   = {r_s & r_a[DP_WIDTH], r_a[DP_WIDTH:1]};
        w_q_sh   = {r_a[0], r_q[DP_WIDTH-1:1]};
    end

    assign Product = {r_a[DP_WIDTH-1:0], r_q};

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_p     <= '0;
            r_s     <= 1'b0;
            Ready   <= 1'b1;
            Done    <= 1'b0;
        end else begin
            Ready <= 1'b0;
            Done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_b     <= Multiplicand;
                        r_q     <= Multiplier;
                        r_a     <= '0;
                        r_p     <= BC_SIZE'(DP_WIDTH);
                        r_s     <= Signed_mode;
                        r_state <= S_ADD;
                    end else begin
                        r_state <= S_IDLE;
                        Ready   <= 1'b1;
                    end
                end
                S_ADD: begin
                    r_p <= r_p - BC_SIZE'(1);
`ifdef SEQ_MULT_SKIP_EN
                    // Zero multiplier bit: shift immediately instead of visiting S_SHIFT.
                    if (!r_q[0]) begin
                        r_a <= w_a_sh;
                        r_q <= w_q_sh;
                        if (w_last) begin
                            r_state <= S_DONE;
                            Done    <= 1'b1;
                        end else begin
                            r_state <= S_ADD;
                        end
                    end else begin
                        r_a     <= w_a_upd;
                        r_state <= S_SHIFT;
                    end
`else
                    if (r_q[0]) begin
                        r_a <= w_a_upd;
                    end
                    r_state <= S_SHIFT;
`endif
                end
                S_SHIFT: begin
                    r_a <= w_a_sh;
                    r_q <= w_q_sh;
                    if (r_p == '0) begin
                        r_state <= S_DONE;
                        Done    <= 1'b1;
                    end else begin
                        r_state <= S_ADD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    Ready   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    Ready   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_signed.sv
// tb_seq_mult_signed: directed vectors checked against a transaction-level multiply model.
module tb_seq_mult_signed;
    localparam int W = 8;

    logic           clock        = 1'b0;
    logic           reset_b      = 1'b0;
    logic           Start        = 1'b0;
    logic           Signed_mode  = 1'b0;
    logic [W-1:0]   Multiplicand = '0;
    logic [W-1:0]   Multiplier   = '0;
    logic [2*W-1:0] Product;
    logic           Ready;
    logic           Done;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mult_signed #(.DP_WIDTH(W)) dut (
        .clock        (clock),
        .reset_b      (reset_b),
        .Start        (Start),
        .Signed_mode  (Signed_mode),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Ready        (Ready),
        .Done         (Done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] b, input logic [W-1:0] q,
                                                   input logic s);
        longint ib, iq, p;
        ib = s ? longint'($signed(b)) : longint'(b);
        iq = s ? longint'($signed(q)) : longint'(q);
        p  = ib * iq;
        return p[2*W-1:0];
    endfunction

    function automatic longint ref_latency(input logic [W-1:0] q);
`ifdef SEQ_MULT_SKIP_EN
        return longint'(W + $countones(q));
`else
        return longint'(2 * W);
`endif
    endfunction

    // Transaction model: one accepted request, busy until one edge after its Done edge.
    bit             m_busy   = 1'b0;
    longint         m_e      = 0;
    longint         m_done_e = 0;
    logic [2*W-1:0] m_res    = '0;
    logic [2*W-1:0] m_held   = '0;
    bit             mon_en   = 1'b0;

    always @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            m_busy = 1'b0;
            m_held = '0;
        end else begin
            m_e++;
            if (m_busy) begin
                if (m_e == m_done_e + 1) begin
                    m_busy = 1'b0;
                    m_held = m_res;
                end
            end else if (Start) begin
                m_busy   = 1'b1;
                m_res    = ref_product(Multiplicand, Multiplier, Signed_mode);
                m_done_e = m_e + ref_latency(Multiplier);
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            check("mon_ready", Ready, !m_busy);
            check("mon_done", Done, (m_busy && m_e == m_done_e));
            if (m_busy && m_e == m_done_e)
                check("mon_product_done", Product, m_res);
            else if (!m_busy)
                check("mon_product_held", Product, m_held);
        end
    end

    task automatic run_op(input string name, input logic [W-1:0] b, input logic [W-1:0] q,
                          input logic s, input logic [2*W-1:0] exp_p,
                          input int lat_ns, input int lat_sk, input bit glitch, input int rst_at);
        int n;
        int exp_lat;
`ifdef SEQ_MULT_SKIP_EN
        exp_lat = lat_sk;
`else
        exp_lat = lat_ns;
`endif
        Multiplicand = b;
        Multiplier   = q;
        Signed_mode  = s;
        Start        = 1'b1;
        @(posedge clock);
        #1;
        Start = 1'b0;
        check({name, "_busy"}, Ready, 0);
        n = 0;
        while (!Done && n <= 100) begin
            @(posedge clock);
            #1;
            n++;
            if (glitch && (n == 3 || n == 9)) begin
                Start        = 1'b1;
                Multiplicand = W'($urandom);
                Multiplier   = W'($urandom);
                Signed_mode  = ~s;
            end else begin
                Start = 1'b0;
            end
            if (n == rst_at) begin
                #2;
                reset_b = 1'b0;
                #1;
                check({name, "_rst_product"}, Product, 0);
                check({name, "_rst_ready"}, Ready, 1);
                check({name, "_rst_done"}, Done, 0);
                return;
            end
        end
        check({name, "_done_seen"}, Done, 1);
        check({name, "_latency"}, n, exp_lat);
        check({name, "_product"}, Product, exp_p);
        @(posedge clock);
        #1;
        check({name, "_ready_after"}, Ready, 1);
        check({name, "_done_after"}, Done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("in_reset_ready", Ready, 1);
        check("in_reset_product", Product, 0);
        reset_b = 1'b1;
        @(negedge clock);
        check("reset_product", Product, 0);
        check("reset_ready", Ready, 1);
        check("reset_done", Done, 0);
        mon_en = 1'b1;

        run_op("u200x150", 8'd200, 8'd150, 1'b0, 16'h7530, 16, 12, 1'b0, -1);
        run_op("sFDx05",   8'hFD,  8'h05,  1'b1, 16'hFFF1, 16, 10, 1'b0, -1);
        run_op("s05xFD",   8'h05,  8'hFD,  1'b1, 16'hFFF1, 16, 15, 1'b0, -1);
        run_op("s80x80",   8'h80,  8'h80,  1'b1, 16'h4000, 16, 9,  1'b0, -1);
        run_op("u80x80",   8'h80,  8'h80,  1'b0, 16'h4000, 16, 9,  1'b0, -1);
        run_op("s7Fx80",   8'h7F,  8'h80,  1'b1, 16'hC080, 16, 9,  1'b0, -1);
        run_op("u255x255", 8'hFF,  8'hFF,  1'b0, 16'hFE01, 16, 16, 1'b1, -1);
        Start = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("hold_product", Product, 16'hFE01);
        check("hold_ready", Ready, 1);

        run_op("u100x100", 8'd100, 8'd100, 1'b0, 16'h2710, 16, 11, 1'b0, 7);
        repeat (2) @(negedge clock);
        reset_b = 1'b1;
        @(negedge clock);
        run_op("u3x4",     8'd3,   8'd4,   1'b0, 16'h000C, 16, 9,  1'b0, -1);
        run_op("u7x1",     8'd7,   8'd1,   1'b0, 16'h0007, 16, 9,  1'b0, -1);
        run_op("u7x0",     8'd7,   8'd0,   1'b0, 16'h0000, 16, 8,  1'b0, -1);
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
